// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the fetch unit: FSM encoding, opcodes shared with the branch unit and
// the instruction width used to step the program counter.
package pc_fetch_unit_pkg;

  typedef enum logic [1:0] {
    StBoot = 2'd0,
    StReq  = 2'd1,
    StDrop = 2'd2
  } fetch_state_e;

  // Opcodes decoded by the branch unit that can produce a redirect.
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;

  // Instruction width in bytes.
  localparam int unsigned InstrBytes = 4;

  // Sequential successor of a PC; wraps modulo 2^32.
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'(InstrBytes);
  endfunction

endpackage

// File: rtl/pc_fetch_unit_flush_counter.sv
// Loadable down-counter that holds the pipeline flush high for a fixed number of cycles after
// each redirect. A load while counting restarts the window.
module pc_fetch_unit_flush_counter #(
  parameter int unsigned Depth = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic flush
);

  logic [2:0] cnt_q;

  // Count down from Depth; flush is registered alongside the count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= 3'd0;
      flush <= 1'b0;
    end else if (load) begin
      cnt_q <= 3'(Depth);
      flush <= 1'b1;
    end else if (cnt_q != 3'd0) begin
      cnt_q <= cnt_q - 3'd1;
      flush <= (cnt_q != 3'd1);
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch unit: owns the PC, issues instruction-memory requests over valid/ready, applies
// branch/jump redirects, squashes stale fetches and drives a multi-cycle pipeline flush.
// Optional feature: define MISALIGN_TRAP_EN to trap on targets with bit 1 set instead of
// silently aligning them.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned FLUSH_DEPTH  = 2
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        JumpTaken,
  input  logic [31:0] JumpTarget,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemReady,
  output logic        FetchValid,
  output logic [31:0] FetchPC,
`ifdef MISALIGN_TRAP_EN
  output logic        TrapMisaligned,
`endif
  output logic        Flush
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  target_q;
  logic         halt_q;

  logic         redirect;
  logic         misaligned;
  logic [31:0]  sel_target;
  logic [31:0]  tgt;
  logic         unused_bits;

  assign redirect   = BranchTaken | JumpTaken;
  // JALR clears bit 0 of its target; a jump wins over a simultaneous branch.
  assign sel_target = JumpTaken ? {JumpTarget[31:1], 1'b0} : BranchTarget;
  assign tgt        = {sel_target[31:2], 2'b00};
  assign unused_bits = ^{JumpTarget[0], sel_target[1:0]};

`ifdef MISALIGN_TRAP_EN
  assign misaligned = sel_target[1];
`else
  assign misaligned = 1'b0;
`endif

  assign ImemAddr = pc_q;
  assign FetchPC  = pc_q;
  // A beat accepted during DROP or in a redirect cycle belongs to the wrong path.
  assign FetchValid = (state_q == StReq) & ImemReq & ImemReady & ~redirect;

  // Fetch FSM with registered request, PC and redirect bookkeeping.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q  <= StBoot;
      pc_q     <= RESET_VECTOR;
      target_q <= RESET_VECTOR;
      halt_q   <= 1'b0;
      ImemReq  <= 1'b0;
    end else begin
      unique case (state_q)
        StBoot: begin
          state_q <= StReq;
          ImemReq <= ~Stall;
        end
        StReq: begin
          if (redirect) begin
            if (ImemReq && !ImemReady) begin
              // Request already on the bus: let it complete, then redirect.
              state_q  <= StDrop;
              target_q <= tgt;
              halt_q   <= misaligned;
            end else if (misaligned) begin
              halt_q  <= 1'b1;
              ImemReq <= 1'b0;
            end else begin
              // Redirect overrides a concurrent stall.
              pc_q    <= tgt;
              ImemReq <= 1'b1;
              halt_q  <= 1'b0;
            end
          end else if (!(ImemReq && !ImemReady)) begin
            if (ImemReq) pc_q <= next_pc(pc_q);
            ImemReq <= ~Stall & ~halt_q;
          end
        end
        StDrop: begin
          if (ImemReady) begin
            state_q <= StReq;
            if (redirect && !misaligned) begin
              pc_q    <= tgt;
              ImemReq <= 1'b1;
              halt_q  <= 1'b0;
            end else if (redirect || halt_q) begin
              halt_q  <= 1'b1;
              ImemReq <= 1'b0;
            end else begin
              pc_q    <= target_q;
              ImemReq <= 1'b1;
            end
          end else if (redirect) begin
            target_q <= tgt;
            halt_q   <= misaligned;
          end
        end
        default: begin
          state_q <= StBoot;
          ImemReq <= 1'b0;
        end
      endcase
    end
  end

`ifdef MISALIGN_TRAP_EN
  // One-cycle trap pulse for a misaligned selected target.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      TrapMisaligned <= 1'b0;
    end else begin
      TrapMisaligned <= redirect & misaligned & (state_q != StBoot);
    end
  end
`endif

  pc_fetch_unit_flush_counter #(
    .Depth(FLUSH_DEPTH)
  ) u_flush_counter (
    .clk  (Clk),
    .rst_n(Rst_n),
    .load (redirect & (state_q != StBoot)),
    .flush(Flush)
  );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with RESET_VECTOR=0x100 and FLUSH_DEPTH=2.
module tb_pc_fetch_unit;

  logic        Clk = 1'b0;
  logic        Rst_n, Stall, BranchTaken, JumpTaken, ImemReady;
  logic [31:0] BranchTarget, JumpTarget;
  logic        ImemReq, FetchValid, Flush;
  logic [31:0] ImemAddr, FetchPC;
`ifdef MISALIGN_TRAP_EN
  logic        TrapMisaligned;
`endif

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  pc_fetch_unit #(
    .RESET_VECTOR(32'h0000_0100),
    .FLUSH_DEPTH (2)
  ) dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .Stall       (Stall),
    .BranchTaken (BranchTaken),
    .BranchTarget(BranchTarget),
    .JumpTaken   (JumpTaken),
    .JumpTarget  (JumpTarget),
    .ImemReq     (ImemReq),
    .ImemAddr    (ImemAddr),
    .ImemReady   (ImemReady),
    .FetchValid  (FetchValid),
    .FetchPC     (FetchPC),
`ifdef MISALIGN_TRAP_EN
    .TrapMisaligned(TrapMisaligned),
`endif
    .Flush       (Flush)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    Rst_n = 1'b0; Stall = 1'b0; ImemReady = 1'b1;
    BranchTaken = 1'b0; BranchTarget = '0; JumpTaken = 1'b0; JumpTarget = '0;
    tick(); tick();
    settle();
    chk("rst_req", 32'(ImemReq), 32'd0);
    chk("rst_addr", ImemAddr, 32'h100);
    chk("rst_flush", 32'(Flush), 32'd0);
    chk("rst_fv", 32'(FetchValid), 32'd0);
`ifdef MISALIGN_TRAP_EN
    chk("rst_trap", 32'(TrapMisaligned), 32'd0);
`endif
    // Boot cycle: no request.
    Rst_n = 1'b1; settle();
    chk("boot_req", 32'(ImemReq), 32'd0);
    // Sequential fetch.
    tick(); settle();
    chk("seq0_addr", ImemAddr, 32'h100);
    chk("seq0_req", 32'(ImemReq), 32'd1);
    chk("seq0_fv", 32'(FetchValid), 32'd1);
    chk("seq0_fpc", FetchPC, 32'h100);
    tick(); settle();
    chk("seq1_addr", ImemAddr, 32'h104);
    chk("seq1_fv", 32'(FetchValid), 32'd1);
    tick();
    BranchTaken = 1'b1; BranchTarget = 32'h200; settle();
    chk("seq2_addr", ImemAddr, 32'h108);
    chk("br_redirect_fv", 32'(FetchValid), 32'd0);
    tick();
    BranchTaken = 1'b0; settle();
    chk("br_addr", ImemAddr, 32'h200);
    chk("br_flush1", 32'(Flush), 32'd1);
    chk("br_fv", 32'(FetchValid), 32'd1);
    tick(); settle();
    chk("br_addr2", ImemAddr, 32'h204);
    chk("br_flush2", 32'(Flush), 32'd1);
    // Jump and branch together: jump wins, bit 0 cleared.
    tick();
    JumpTaken = 1'b1; JumpTarget = 32'h301; BranchTaken = 1'b1; BranchTarget = 32'h400;
    settle();
    chk("br_flush_end", 32'(Flush), 32'd0);
    chk("br_addr3", ImemAddr, 32'h208);
    tick();
    JumpTaken = 1'b0; BranchTaken = 1'b0; settle();
    chk("jmp_addr", ImemAddr, 32'h300);
    chk("jmp_flush", 32'(Flush), 32'd1);
    tick(); settle();
    chk("jmp_addr2", ImemAddr, 32'h304);
    // Redirect with the request stalled by memory for three cycles.
    tick();
    ImemReady = 1'b0; BranchTaken = 1'b1; BranchTarget = 32'h500; settle();
    chk("drop_addr0", ImemAddr, 32'h308);
    chk("drop_fv0", 32'(FetchValid), 32'd0);
    tick();
    BranchTaken = 1'b0; settle();
    chk("drop_addr1", ImemAddr, 32'h308);
    chk("drop_req1", 32'(ImemReq), 32'd1);
    chk("drop_flush1", 32'(Flush), 32'd1);
    tick(); settle();
    chk("drop_addr2", ImemAddr, 32'h308);
    tick();
    ImemReady = 1'b1; settle();
    chk("drop_addr3", ImemAddr, 32'h308);
    chk("drop_stale_fv", 32'(FetchValid), 32'd0);
    tick(); settle();
    chk("drop_target", ImemAddr, 32'h500);
    chk("drop_target_fv", 32'(FetchValid), 32'd1);
    // Stall cannot withdraw an outstanding request.
    ImemReady = 1'b0; Stall = 1'b1; settle();
    chk("stall_fv", 32'(FetchValid), 32'd0);
    tick(); settle();
    chk("stall_req1", 32'(ImemReq), 32'd1);
    chk("stall_addr1", ImemAddr, 32'h500);
    tick(); settle();
    chk("stall_req2", 32'(ImemReq), 32'd1);
    chk("stall_addr2", ImemAddr, 32'h500);
    // Redirect under stall still updates the PC.
    ImemReady = 1'b1; BranchTaken = 1'b1; BranchTarget = 32'h600; settle();
    chk("stall_br_fv", 32'(FetchValid), 32'd0);
    tick();
    BranchTaken = 1'b0; settle();
    chk("stall_br_addr", ImemAddr, 32'h600);
    chk("stall_br_req", 32'(ImemReq), 32'd1);
    chk("stall_br_fv2", 32'(FetchValid), 32'd1);
    tick(); settle();
    chk("stall_noreq", 32'(ImemReq), 32'd0);
    chk("stall_pc", ImemAddr, 32'h604);
    Stall = 1'b0;
    tick();
    BranchTaken = 1'b1; BranchTarget = 32'hFFFF_FFFC; settle();
    chk("unstall_req", 32'(ImemReq), 32'd1);
    chk("unstall_addr", ImemAddr, 32'h604);
    // PC wraps from the top of the address space.
    tick();
    BranchTaken = 1'b0; settle();
    chk("wrap_top", ImemAddr, 32'hFFFF_FFFC);
    chk("wrap_top_fv", 32'(FetchValid), 32'd1);
    tick();
    BranchTaken = 1'b1; BranchTarget = 32'h202; settle();
    chk("wrap_zero", ImemAddr, 32'h0);
    tick();
    BranchTaken = 1'b0; settle();
    chk("mis_flush", 32'(Flush), 32'd1);
`ifdef MISALIGN_TRAP_EN
    chk("mis_trap", 32'(TrapMisaligned), 32'd1);
    chk("mis_noreq", 32'(ImemReq), 32'd0);
`else
    chk("mis_aligned_addr", ImemAddr, 32'h200);
`endif
    BranchTaken = 1'b1; BranchTarget = 32'h700;
    tick();
    BranchTaken = 1'b0; settle();
    chk("late_addr", ImemAddr, 32'h700);
    chk("late_req", 32'(ImemReq), 32'd1);
    chk("late_flush", 32'(Flush), 32'd1);
`ifdef MISALIGN_TRAP_EN
    chk("trap_pulse_end", 32'(TrapMisaligned), 32'd0);
`endif
    // Reset in the middle of a flush window.
    Rst_n = 1'b0;
    tick(); settle();
    chk("midrst_flush", 32'(Flush), 32'd0);
    chk("midrst_req", 32'(ImemReq), 32'd0);
    chk("midrst_addr", ImemAddr, 32'h100);
    chk("midrst_fv", 32'(FetchValid), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
